// File: rtl/pq_pkg.sv
// Shared types and defaults for the register-array priority queue.
// Operation decode folds full/empty so the datapath never has to re-check them.
package pq_pkg;

  localparam int DEF_QUEUE_SIZE = 8;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ENQ,
    OP_DEQ,
    OP_REPL
  } op_t;

  // A replace on an empty queue has nothing to remove, so it degenerates to an enqueue.
  function automatic op_t decode_op(input logic wrt, input logic read,
                                    input logic full, input logic empty);
    op_t op;
    op = OP_NONE;
    if (wrt && read)
      op = empty ? OP_ENQ : OP_REPL;
    else if (wrt)
      op = full ? OP_NONE : OP_ENQ;
    else if (read)
      op = empty ? OP_NONE : OP_DEQ;
    return op;
  endfunction

endpackage

// File: rtl/register_array_cell.sv
// One slot of the sorted array: data + valid, with its insert-compare against
// both the current array (gt) and the head-removed array (gt_sh).
module register_array_cell
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  op_t                   op,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] prev_data,
  input  logic                  prev_valid,
  input  logic                  prev_gt,
  input  logic                  prev_gt_sh,
  input  logic [DATA_WIDTH-1:0] next_data,
  input  logic                  next_valid,
  output logic                  gt,
  output logic                  gt_sh,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt;

  // Strict compare places a new entry behind existing equal entries.
  assign gt    = !valid || (i_data > data);
  assign gt_sh = !next_valid || (i_data > next_data);

  always_comb begin
    data_nxt  = data;
    valid_nxt = valid;
    unique case (op)
      OP_ENQ: begin
        if (prev_gt) begin
          data_nxt  = prev_data;
          valid_nxt = prev_valid;
        end else if (gt) begin
          data_nxt  = i_data;
          valid_nxt = 1'b1;
        end
      end
      OP_DEQ: begin
        data_nxt  = next_data;
        valid_nxt = next_valid;
      end
      OP_REPL: begin
        // In the shifted view this slot's predecessor is its own current content.
        if (prev_gt_sh) begin
          data_nxt  = data;
          valid_nxt = valid;
        end else if (gt_sh) begin
          data_nxt  = i_data;
          valid_nxt = 1'b1;
        end else begin
          data_nxt  = next_data;
          valid_nxt = next_valid;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= data_nxt;
      valid <= valid_nxt;
    end
  end

endmodule

// File: rtl/register_array.sv
// Max-priority queue held sorted (descending) in a linear register array.
// Enqueue, dequeue and replace each complete in one clock; head is always on o_data.
module register_array
  import pq_pkg::*;
#(
  parameter int QUEUE_SIZE = DEF_QUEUE_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);

  logic [DATA_WIDTH-1:0] data  [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] valid;
  logic [QUEUE_SIZE-1:0] gt;
  logic [QUEUE_SIZE-1:0] gt_sh;
  logic [CW-1:0]         count;
  logic                  ins_fits;
  op_t                   op;

  assign o_full  = (count == CW'(QUEUE_SIZE));
  assign o_empty = (count == '0);
  assign o_data  = data[0];
  assign op      = decode_op(i_wrt, i_read, o_full, o_empty);

  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_cell
    logic [DATA_WIDTH-1:0] prev_data, next_data;
    logic                  prev_valid, prev_gt, prev_gt_sh, next_valid;

    if (i == 0) begin : g_head
      assign prev_data  = '0;
      assign prev_valid = 1'b0;
      assign prev_gt    = 1'b0;
      assign prev_gt_sh = 1'b0;
    end else begin : g_body
      assign prev_data  = data[i-1];
      assign prev_valid = valid[i-1];
      assign prev_gt    = gt[i-1];
      assign prev_gt_sh = gt_sh[i-1];
    end

    if (i == QUEUE_SIZE - 1) begin : g_tail
      assign next_data  = '0;
      assign next_valid = 1'b0;
    end else begin : g_mid
      assign next_data  = data[i+1];
      assign next_valid = valid[i+1];
    end

    register_array_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .op         (op),
      .i_data     (i_data),
      .prev_data  (prev_data),
      .prev_valid (prev_valid),
      .prev_gt    (prev_gt),
      .prev_gt_sh (prev_gt_sh),
      .next_data  (next_data),
      .next_valid (next_valid),
      .gt         (gt[i]),
      .gt_sh      (gt_sh[i]),
      .data       (data[i]),
      .valid      (valid[i])
    );
  end

  // New value lands somewhere in the array iff the tail slot would accept it.
  assign ins_fits = (op == OP_REPL) ? gt_sh[QUEUE_SIZE-1] : gt[QUEUE_SIZE-1];

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_ENQ:  if (ins_fits) count <= count + CW'(1);
        OP_DEQ:  count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_register_array.sv
// Scoreboard bench for register_array: a sorted software queue predicts the
// head/full/empty after every operation; predictions are queued and popped on output.
module tb_register_array;

  localparam int N = 8;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         i_wrt, i_read;
  logic [W-1:0] i_data;
  logic         o_full, o_empty;
  logic [W-1:0] o_data;

  typedef struct {
    string        tag;
    logic [W-1:0] data;
    logic         full;
    logic         empty;
  } exp_t;

  exp_t sb[$];
  int   model[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  register_array #(.QUEUE_SIZE(N), .DATA_WIDTH(W)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .i_wrt   (i_wrt),
    .i_read  (i_read),
    .i_data  (i_data),
    .o_full  (o_full),
    .o_empty (o_empty),
    .o_data  (o_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_insert(input int v);
    for (int i = 0; i < model.size(); i++) begin
      if (model[i] < v) begin
        model.insert(i, v);
        return;
      end
    end
    model.push_back(v);
  endfunction

  function automatic void model_op(input logic w, input logic r, input int d);
    if (w && r) begin
      if (model.size() != 0) void'(model.pop_front());
      model_insert(d);
    end else if (w) begin
      if (model.size() < N) model_insert(d);
    end else if (r) begin
      if (model.size() > 0) void'(model.pop_front());
    end
  endfunction

  function automatic void push_exp(input string tag);
    exp_t e;
    e.tag   = tag;
    e.data  = (model.size() > 0) ? W'(model[0]) : '0;
    e.full  = (model.size() == N);
    e.empty = (model.size() == 0);
    sb.push_back(e);
  endfunction

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "_data"},  32'(o_data),  32'(e.data));
    check({e.tag, "_full"},  32'(o_full),  32'(e.full));
    check({e.tag, "_empty"}, 32'(o_empty), 32'(e.empty));
  endtask

  task automatic do_op(input string tag, input logic w, input logic r, input int d);
    @(negedge CLK);
    i_wrt  = w;
    i_read = r;
    i_data = W'(d);
    model_op(w, r, d);
    push_exp(tag);
    @(posedge CLK);
    #1;
    compare_out();
    i_wrt  = 1'b0;
    i_read = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    @(negedge CLK);
    i_wrt  = 1'b1;
    i_read = 1'b0;
    i_data = W'(77);
    #2 RSTn = 1'b1;
    model.delete();
    push_exp({tag, "_now"});
    #1 compare_out();
    push_exp({tag, "_held"});
    @(posedge CLK);
    #1 compare_out();
    @(negedge CLK);
    RSTn   = 1'b0;
    i_wrt  = 1'b0;
  endtask

  int fill_vals[8]  = '{5, 900, 17, 900, 0, 1024, 300, 64};
  int drain_vals[8] = '{900, 900, 300, 64, 17, 5, 0, 0};

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    RSTn   = 1'b1;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    i_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    push_exp("reset");
    compare_out();

    foreach (fill_vals[i]) do_op("fill", 1'b1, 1'b0, fill_vals[i]);
    check("fill_max", 32'(o_data), 1024);
    check("fill_full", 32'(o_full), 1);
    do_op("enq_full", 1'b1, 1'b0, 1000);
    check("enq_full_ignored", 32'(o_data), 1024);

    foreach (drain_vals[i]) begin
      do_op("drain", 1'b0, 1'b1, 0);
      check("drain_seq", 32'(o_data), 32'(drain_vals[i]));
    end
    check("drain_empty", 32'(o_empty), 1);
    do_op("deq_empty", 1'b0, 1'b1, 0);
    do_op("enq_after_underflow", 1'b1, 1'b0, 9);
    do_op("deq_one", 1'b0, 1'b1, 0);
    check("no_underflow_empty", 32'(o_empty), 1);

    foreach (fill_vals[i]) do_op("refill", 1'b1, 1'b0, fill_vals[i]);
    do_op("repl_small", 1'b1, 1'b1, 2);
    check("repl_small_head", 32'(o_data), 900);
    check("repl_small_full", 32'(o_full), 1);
    do_op("repl_big", 1'b1, 1'b1, 2000);
    check("repl_big_head", 32'(o_data), 2000);
    repeat (8) do_op("drain2", 1'b0, 1'b1, 0);
    check("drain2_empty", 32'(o_empty), 1);

    do_op("repl_empty", 1'b1, 1'b1, 42);
    check("repl_empty_head", 32'(o_data), 42);
    check("repl_empty_nonempty", 32'(o_empty), 0);
    do_op("repl_empty_count1", 1'b0, 1'b1, 0);
    check("repl_empty_count1_empty", 32'(o_empty), 1);

    for (int k = 0; k < 160; k++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (k == 80) async_reset("mid_reset");
      unique case (sel)
        0, 1: do_op("rnd_enq", 1'b1, 1'b0, int'($urandom_range(0, 1024)));
        2:    do_op("rnd_deq", 1'b0, 1'b1, int'($urandom_range(0, 1024)));
        default: do_op("rnd_repl", 1'b1, 1'b1, int'($urandom_range(0, 1024)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_array.md
Name: register_array

Overview:
- Register-based max-priority queue of QUEUE_SIZE entries, kept sorted in descending order in a linear array of registers.
- Supports enqueue (insert), dequeue (remove max) and replace (remove max plus insert), each completing in a single clock cycle.
- The head entry (current maximum) is always presented on o_data.
- Used as the baseline hardware priority-queue block in the scheduler datapath.

Parameters:
- QUEUE_SIZE, 8: number of entries; must be at least 2.
- DATA_WIDTH, 16: entry width in bits; entries are compared as unsigned values.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RSTn  input  1  reset, asynchronous and active-high (asserted when 1), despite the name.
- i_wrt  input  1  write request; pushes i_data.
- i_read  input  1  read request; pops the head entry.
- i_data  input  DATA_WIDTH  value to insert, sampled on the edge where i_wrt=1.
- o_full  output  1  high when count == QUEUE_SIZE.
- o_empty  output  1  high when count == 0.
- o_data  output  DATA_WIDTH  current maximum (slot 0); 0 when empty.

Behaviour:
- State:
  - slot[0..QUEUE_SIZE-1] data registers, each with a valid bit.
  - count register, 0..QUEUE_SIZE.
  - Invariants: valid slots are contiguous from slot 0; data is non-increasing with index; invalid slots hold 0.
- Reset: while RSTn=1, all slots are 0 and invalid, count=0, so o_empty=1, o_full=0, o_data=0. Reset asserted mid-operation discards any pending request.
- Outputs are combinational from registers. The result of an operation is visible one cycle after the sampling edge.
- Operation decode, per rising edge:
  - i_wrt=1, i_read=0: enqueue. If not full, insert i_data at its sorted position; lower-priority valid entries shift one slot toward the tail; count+1. If full, ignore (no state change).
  - i_wrt=0, i_read=1: dequeue. If not empty, shift every slot toward the head by one; the tail slot becomes invalid/0; count-1. If empty, ignore.
  - i_wrt=1, i_read=1: replace, completed in one cycle.
    - Not empty: remove slot 0, then insert i_data in sorted position among the remaining entries; count unchanged. Allowed when full.
    - Empty: behaves exactly as enqueue (count becomes 1).
  - Both low: hold.
- Insert rule, evaluated in parallel per slot i:
  - gt[i] = !valid[i] or i_data > data[i].
  - Slot i takes i_data when gt[i] and (i==0 or !gt[i-1]).
  - Slot i takes data[i-1] when gt[i-1].
  - Otherwise slot i holds.
  - Ties: the new entry goes after existing equal entries. Order among equal values is not externally observable.
- Replace uses the same rule applied to the shifted-left array.
- No wrap-around: the array is linear, with no head/tail pointers.
- i_data is ignored when i_wrt=0.

Decomposition:
- Shared package pq_pkg holds:
  - typedef enum op_t {OP_NONE, OP_ENQ, OP_DEQ, OP_REPL}, decoded from {i_wrt, i_read} and gated with full/empty.
  - Default width/size localparams.
- One sub-module is natural: register_array_cell. It holds one slot (data + valid), takes neighbour data/valid/gt inputs and op_t, and produces next state plus its own gt. register_array instantiates QUEUE_SIZE cells in a generate loop and owns count and the outputs.

Test Plan:
- Reset: hold RSTn=1 for 2 cycles, then release -> o_empty=1, o_full=0, o_data=0.
- Fill with 8 enqueues of 5, 900, 17, 900, 0, 1024, 300, 64 -> o_data=1024 after the last one; o_full=1. A 9th enqueue of 1000 is ignored and o_data stays 1024.
- Drain with 8 dequeues -> o_data sequence 900, 900, 300, 64, 17, 5, 0, then 0 with o_empty=1. A further dequeue is ignored, with no state change or count underflow.
- Replace on a full queue holding 8 entries (max 1024), with i_data=2 -> o_data=900 and count stays 8. Replace with i_data=2000 -> o_data=2000.
- Replace on an empty queue with i_data=42 -> o_empty=0, o_data=42, count=1.
- Random stress: 100+ mixed enqueue/dequeue/replace operations with values 0..1024. After every operation, compare o_data, o_full and o_empty against a sorted software model; assert RSTn asynchronously mid-sequence -> immediate return to the empty state.
